// File: rtl/sipo_reg_rx.sv
// Purpose : UART receive deserializer. 16x oversampled start detect, 7/8 data bits LSB first,
//           optional odd/even parity, 1/2 stop bits, parallel word plus status flags.
// Latency : line fall to start edge E0 is 2-3 cycles; rx_done is high the cycle after E0 + 8 + 16*(F-1).
// Backpr. : none. rx_done is a single-cycle strobe and outputs hold until the next completed frame.
//
// Ports:
//   BaudOut      - 16x bit-rate clock, rising edge
//   rst          - asynchronous active-low reset
//   data_tx      - serial line, idle high, asynchronous to BaudOut
//   parity_type  - 00/11 none, 01 odd, 10 even (latched at start edge)
//   stop_bits    - 0 one stop bit, 1 two stop bits (latched at start edge)
//   data_length  - 0 seven data bits, 1 eight data bits (latched at start edge)
//   data_parll   - received word, bit 7 zero in 7-bit mode
//   rx_active    - frame reception in progress
//   rx_done      - one-cycle frame complete strobe
//   parity_error - parity mismatch in last frame
//   stop_error   - a stop bit sampled low in last frame
module sipo_reg_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       BaudOut,
    input  logic       rst,
    input  logic       data_tx,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_parll,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int            TW  = $clog2(OVERSAMPLE);
    // Tick value seen just before the mid-bit edge (E0 + 8 + 16k).
    localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic          r_len8;
    logic [1:0]    r_ptype;
    logic          r_stop2;
    logic [7:0]    r_shift;
    logic          r_par_acc;
    logic          r_stop_acc;
    logic [7:0]    r_data;
    logic          r_active;
    logic          r_done;
    logic          r_par_err;
    logic          r_stop_err;

    logic          w_sample;
    logic          w_fall;
    logic          w_mid;
    logic [2:0]    w_last_data;
    logic          w_par_err;

    assign w_sample    = r_sync2;
    // Needs a high level before the low one, so a held-low line never re-triggers.
    assign w_fall      = r_prev & ~r_sync2;
    assign w_mid       = (r_tick == MID);
    assign w_last_data = r_len8 ? 3'd7 : 3'd6;

    // r_par_acc holds XOR of data bits and received parity bit.
    always_comb begin
        w_par_err = 1'b0;
        case (r_ptype)
            2'b01:   w_par_err = ~r_par_acc;
            2'b10:   w_par_err = r_par_acc;
            default: w_par_err = 1'b0;
        endcase
    end

    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_tick     <= '0;
            r_bit      <= '0;
            r_len8     <= 1'b0;
            r_ptype    <= 2'b00;
            r_stop2    <= 1'b0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_stop_acc <= 1'b0;
            r_data     <= '0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_sync1 <= data_tx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_done  <= 1'b0;

            if (r_state == S_IDLE) begin
                if (w_fall) begin
                    r_state    <= S_START;
                    r_tick     <= '0;
                    r_bit      <= '0;
                    r_active   <= 1'b1;
                    r_len8     <= data_length;
                    r_ptype    <= parity_type;
                    r_stop2    <= stop_bits;
                    r_shift    <= '0;
                    r_par_acc  <= 1'b0;
                    r_stop_acc <= 1'b0;
                end
            end else begin
                r_tick <= r_tick + TW'(1);
                if (w_mid) begin
                    case (r_state)
                        S_START: begin
                            if (w_sample) begin
                                // False start: abandon quietly, outputs untouched.
                                r_state  <= S_IDLE;
                                r_active <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                                r_bit   <= '0;
                            end
                        end
                        S_DATA: begin
                            r_shift[r_bit] <= w_sample;
                            r_par_acc      <= r_par_acc ^ w_sample;
                            if (r_bit == w_last_data) begin
                                r_bit   <= '0;
                                r_state <= (r_ptype == 2'b01 || r_ptype == 2'b10) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                        S_PARITY: begin
                            r_par_acc <= r_par_acc ^ w_sample;
                            r_state   <= S_STOP;
                        end
                        S_STOP: begin
                            if (r_bit == {2'b00, r_stop2}) begin
                                // Last sample: publish the frame, back to IDLE at mid stop bit.
                                r_data     <= r_len8 ? r_shift : {1'b0, r_shift[6:0]};
                                r_par_err  <= w_par_err;
                                r_stop_err <= r_stop_acc | ~w_sample;
                                r_done     <= 1'b1;
                                r_active   <= 1'b0;
                                r_state    <= S_IDLE;
                            end else begin
                                r_stop_acc <= r_stop_acc | ~w_sample;
                                r_bit      <= r_bit + 3'd1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign data_parll   = r_data;
    assign rx_active    = r_active;
    assign rx_done      = r_done;
    assign parity_error = r_par_err;
    assign stop_error   = r_stop_err;

endmodule

// File: tb/tb_sipo_reg_rx.sv
// Purpose : directed self-checking bench for sipo_reg_rx.
// Latency : stimulus driven 1 time unit after each rising edge, outputs sampled there or on falling edge.
// Backpr. : none; rx_done strobes are counted by a falling-edge monitor.
module tb_sipo_reg_rx;

    logic       BaudOut;
    logic       rst;
    logic       data_tx;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic [7:0] data_parll;
    logic       rx_active;
    logic       rx_done;
    logic       parity_error;
    logic       stop_error;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int act_cnt  = 0;

    sipo_reg_rx #(.OVERSAMPLE(16)) dut (
        .BaudOut      (BaudOut),
        .rst          (rst),
        .data_tx      (data_tx),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_parll   (data_parll),
        .rx_active    (rx_active),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    initial begin
        BaudOut = 1'b0;
        forever #5 BaudOut = ~BaudOut;
    end

    always @(posedge BaudOut) cyc++;

    always @(negedge BaudOut) begin
        if (rx_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Drive the line for n cycles; sample rx_active after each edge.
    task automatic hold(input logic b, input int n);
        data_tx = b;
        for (int i = 0; i < n; i++) begin
            @(posedge BaudOut);
            #1;
            if (rx_active === 1'b1) act_cnt++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input int nstop, input logic stop2v, output int c0);
        c0      = cyc;
        act_cnt = 0;
        hold(1'b0, 16);
        for (int i = 0; i < nbits; i++) hold(d[i], 16);
        if (par >= 0) hold(par[0], 16);
        hold(1'b1, 16);
        if (nstop == 2) hold(stop2v, 16);
    endtask

    task automatic set_cfg(input logic dl, input logic [1:0] pt, input logic sb);
        data_length = dl;
        parity_type = pt;
        stop_bits   = sb;
    endtask

    task automatic test_reset;
        checks++;
        if (data_parll !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data_parll); end
        checks++;
        if (rx_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", rx_active); end
        checks++;
        if (rx_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", rx_done); end
        checks++;
        if (parity_error !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", parity_error); end
        checks++;
        if (stop_error !== 1'b0) begin errors++; $display("FAIL rst_serr: got %b want 0", stop_error); end
    endtask

    task automatic test_8n1;
        int c0, d0;
        set_cfg(1'b1, 2'b00, 1'b0);
        hold(1'b1, 8);
        d0 = done_cnt;
        send_frame(8'hA5, 8, -1, 1, 1'b1, c0);
        checks++;
        if (data_parll !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h want a5", data_parll); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL 8n1_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++;
        if (done_cyc !== c0 + 155) begin errors++; $display("FAIL 8n1_done_time: got %0d want %0d", done_cyc, c0 + 155); end
        checks++;
        if (act_cnt !== 152) begin errors++; $display("FAIL 8n1_active_len: got %0d want 152", act_cnt); end
        checks++;
        if (parity_error !== 1'b0 || stop_error !== 1'b0) begin
            errors++; $display("FAIL 8n1_errs: got p=%b s=%b want 0 0", parity_error, stop_error);
        end
    endtask

    task automatic test_parity_odd;
        int c0;
        set_cfg(1'b1, 2'b01, 1'b0);
        hold(1'b1, 8);
        // 0x94 has three ones: odd parity bit should be 0, so 1 is wrong.
        send_frame(8'h94, 8, 1, 1, 1'b1, c0);
        checks++;
        if (data_parll !== 8'h94) begin errors++; $display("FAIL 8o1_bad_data: got %h want 94", data_parll); end
        checks++;
        if (parity_error !== 1'b1) begin errors++; $display("FAIL 8o1_bad_perr: got %b want 1", parity_error); end
        checks++;
        if (done_cyc !== c0 + 171) begin errors++; $display("FAIL 8o1_done_time: got %0d want %0d", done_cyc, c0 + 171); end
        hold(1'b1, 8);
        send_frame(8'h94, 8, 0, 1, 1'b1, c0);
        checks++;
        if (parity_error !== 1'b0) begin errors++; $display("FAIL 8o1_good_perr: got %b want 0", parity_error); end
        checks++;
        if (stop_error !== 1'b0) begin errors++; $display("FAIL 8o1_good_serr: got %b want 0", stop_error); end
    endtask

    task automatic test_7e2;
        int c0, d0;
        set_cfg(1'b0, 2'b10, 1'b1);
        hold(1'b1, 8);
        d0 = done_cnt;
        send_frame(8'h52, 7, 1, 2, 1'b1, c0);
        checks++;
        if (data_parll !== 8'h52) begin errors++; $display("FAIL 7e2_data: got %h want 52", data_parll); end
        checks++;
        if (done_cyc !== c0 + 171) begin errors++; $display("FAIL 7e2_done_time: got %0d want %0d", done_cyc, c0 + 171); end
        checks++;
        if (act_cnt !== 168) begin errors++; $display("FAIL 7e2_active_len: got %0d want 168", act_cnt); end
        checks++;
        if (parity_error !== 1'b0 || stop_error !== 1'b0) begin
            errors++; $display("FAIL 7e2_errs: got p=%b s=%b want 0 0", parity_error, stop_error);
        end
        hold(1'b1, 8);
        send_frame(8'h52, 7, 1, 2, 1'b0, c0);
        checks++;
        if (stop_error !== 1'b1) begin errors++; $display("FAIL 7e2_stop2_serr: got %b want 1", stop_error); end
        checks++;
        if (data_parll !== 8'h52) begin errors++; $display("FAIL 7e2_stop2_data: got %h want 52", data_parll); end
        checks++;
        if (done_cnt - d0 !== 2) begin errors++; $display("FAIL 7e2_done_cnt: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_glitch;
        int d0;
        set_cfg(1'b1, 2'b00, 1'b0);
        hold(1'b1, 8);
        d0      = done_cnt;
        act_cnt = 0;
        hold(1'b0, 4);
        hold(1'b1, 40);
        checks++;
        if (act_cnt !== 8) begin errors++; $display("FAIL glitch_active_len: got %0d want 8", act_cnt); end
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL glitch_no_done: got %0d pulses want 0", done_cnt - d0); end
        checks++;
        if (data_parll !== 8'h52 || stop_error !== 1'b1 || parity_error !== 1'b0) begin
            errors++; $display("FAIL glitch_hold: got d=%h s=%b p=%b want 52 1 0", data_parll, stop_error, parity_error);
        end
    endtask

    task automatic test_back_to_back;
        int c0, c1, first_done;
        set_cfg(1'b1, 2'b00, 1'b0);
        hold(1'b1, 8);
        send_frame(8'h3C, 8, -1, 1, 1'b1, c0);
        first_done = done_cyc;
        checks++;
        if (data_parll !== 8'h3C) begin errors++; $display("FAIL b2b_first_data: got %h want 3c", data_parll); end
        send_frame(8'hC3, 8, -1, 1, 1'b1, c1);
        checks++;
        if (data_parll !== 8'hC3) begin errors++; $display("FAIL b2b_second_data: got %h want c3", data_parll); end
        checks++;
        if (done_cyc - first_done !== 160) begin
            errors++; $display("FAIL b2b_spacing: got %0d want 160", done_cyc - first_done);
        end
    endtask

    task automatic test_break;
        int c0, d0;
        set_cfg(1'b1, 2'b00, 1'b0);
        d0 = done_cnt;
        c0 = cyc;
        hold(1'b0, 480);
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL break_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++;
        if (done_cyc !== c0 + 155) begin errors++; $display("FAIL break_done_time: got %0d want %0d", done_cyc, c0 + 155); end
        checks++;
        if (data_parll !== 8'h00 || stop_error !== 1'b1) begin
            errors++; $display("FAIL break_frame: got d=%h s=%b want 00 1", data_parll, stop_error);
        end
        hold(1'b1, 32);
        send_frame(8'h5A, 8, -1, 1, 1'b1, c0);
        checks++;
        if (data_parll !== 8'h5A || stop_error !== 1'b0) begin
            errors++; $display("FAIL break_recover: got d=%h s=%b want 5a 0", data_parll, stop_error);
        end
        checks++;
        if (done_cnt - d0 !== 2) begin errors++; $display("FAIL break_total_done: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame;
        int c0, d0;
        set_cfg(1'b1, 2'b01, 1'b0);
        hold(1'b1, 8);
        d0 = done_cnt;
        hold(1'b0, 16);
        hold(1'b1, 48);
        checks++;
        if (rx_active !== 1'b1) begin errors++; $display("FAIL rstmid_active_before: got %b want 1", rx_active); end
        rst = 1'b0;
        #1;
        checks++;
        if (data_parll !== 8'h00 || rx_active !== 1'b0 || rx_done !== 1'b0 ||
            parity_error !== 1'b0 || stop_error !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got d=%h a=%b dn=%b p=%b s=%b want all 0",
                     data_parll, rx_active, rx_done, parity_error, stop_error);
        end
        hold(1'b1, 3);
        rst = 1'b1;
        hold(1'b1, 200);
        checks++;
        if (done_cnt !== d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        set_cfg(1'b1, 2'b00, 1'b0);
        send_frame(8'h81, 8, -1, 1, 1'b1, c0);
        checks++;
        if (data_parll !== 8'h81 || done_cyc !== c0 + 155) begin
            errors++; $display("FAIL rstmid_recover: got d=%h t=%0d want 81 %0d", data_parll, done_cyc, c0 + 155);
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_tx = 1'b1;
        set_cfg(1'b1, 2'b00, 1'b0);
        #2 rst = 1'b0;
        repeat (3) @(posedge BaudOut);
        #1;
        test_reset;
        rst = 1'b1;
        hold(1'b1, 4);
        test_reset;
        test_8n1;
        test_parity_odd;
        test_7e2;
        test_glitch;
        test_back_to_back;
        test_break;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_reg_rx.md
# sipo_reg_rx

UART receive deserializer: the stage directly downstream of the transmit serializer (`PisoReg`). It samples the serial line with a 16× oversampled clock and detects the start bit. It then shifts in 7 or 8 data bits LSB-first, checks optional odd/even parity and 1 or 2 stop bits, and presents the parallel word with status flags. Frame-format inputs use the same encoding as the transmitter, so a Tx/Rx pair configured identically interoperates.

## Interface
- `OVERSAMPLE`, 16: `BaudOut` ticks per bit. Fixed at 16; the sample-point arithmetic below assumes 16.
- `BaudOut`  in  1  Clock, 16× the bit rate; all logic on rising edge.
- `rst`  in  1  Reset, asynchronous, active-low.
- `data_tx`  in  1  Serial line, idle high; asynchronous to `BaudOut`.
- `parity_type`  in  2  00 none, 01 odd, 10 even, 11 none.
- `stop_bits`  in  1  0: one stop bit; 1: two stop bits.
- `data_length`  in  1  0: 7 data bits; 1: 8 data bits.
- `data_parll`  out  8  Received word; bit 7 forced 0 in 7-bit mode.
- `rx_active`  out  1  Frame reception in progress.
- `rx_done`  out  1  One-cycle pulse: frame complete, outputs valid.
- `parity_error`  out  1  Parity mismatch in last frame; always 0 when parity is none.
- `stop_error`  out  1  Any stop bit sampled 0 in last frame (framing/break).

## Operation
- Input conditioning: 2-flop synchronizer on `data_tx`, reset value 1, then a one-flop delayed copy for edge detection.
- Start detection: in IDLE, a synchronized falling edge (prev 1, now 1→0) on edge E0 moves the FSM to START.
  - `parity_type`, `stop_bits` and `data_length` are latched at E0; changes mid-frame are ignored.
  - A line held low never re-triggers. After a break, a high level must be seen before the next start is accepted.
- Frame length F = 1 + N + P + S, where N = 7/8, P = 0/1 and S = 1/2.
- Sample point k (k = 0..F-1) is edge E0 + 8 + 16k, one mid-bit sample per bit. A tick counter counts 0..15 and a bit counter tracks k.
- FSM states: IDLE → START → DATA → PARITY (skipped when P = 0) → STOP → IDLE.
  - START, k = 0: sample 1 means a false start; return to IDLE with no `rx_done` and no output change. Sample 0 moves to DATA.
  - DATA: shift the sample into bit position k-1, LSB first; after N bits go to PARITY or STOP.
  - PARITY: capture the received parity bit. The check is the XOR of the data bits and the parity bit: odd mode requires 1, even mode requires 0.
  - STOP: sample S stop bits. A 0 in any of them sets the frame's stop error.
- Completion on the last sample edge (k = F-1):
  - Register `data_parll`, `parity_error` and `stop_error`.
  - Pulse `rx_done`, drop `rx_active`, return to IDLE.
  - Data is delivered even when an error flag is set.
- Output hold: `data_parll` and both error flags hold their values until the next completed frame. A false start does not alter them.
- Back-to-back frames: IDLE is entered at the mid-point of the last stop bit, so a start edge arriving right after the stop bit is detected.

## Timing
- Reset (asynchronous, on `rst` = 0): FSM to IDLE, counters 0, `data_parll` = 0, `rx_active` = 0, `rx_done` = 0, `parity_error` = 0, `stop_error` = 0, synchronizer flops = 1.
- Reset mid-frame aborts the frame immediately with no `rx_done`. After reset is released, the first falling edge is required to start a new frame.
- Latency:
  - Line fall to E0: 2–3 cycles (synchronizer plus edge detect).
  - E0 to `rx_done`: `rx_done` is high in the cycle after edge E0 + 8 + 16(F-1).
  - Example: 8N1 (F = 10) gives edge E0 + 152; 7E2 (F = 11) gives edge E0 + 168.
- `rx_active` is 1 from the cycle after E0 through edge E0 + 8 + 16(F-1). It is never high in the same cycle as `rx_done`.
- False start: `rx_active` deasserts after edge E0 + 8.
- `rx_done` is exactly 1 cycle wide; there is no handshake and the consumer must capture it in that cycle.

## Test plan
- 8N1 (`data_length`=1, `parity_type`=00, `stop_bits`=0), frame for 0xA5, 16 ticks/bit → `data_parll`=8'hA5, `rx_done` one cycle after edge E0+152, both errors 0.
- 8O1, data 0x94 with parity bit 1 (wrong) → `data_parll`=8'h94, `parity_error`=1. Repeat with parity bit 0 → `parity_error`=0.
- 7E2, data 7'h52 with parity bit 1 → `data_parll`=8'h52, `rx_done` after edge E0+168. Second stop bit driven 0 → `stop_error`=1, data still 8'h52.
- Glitch: line low for 4 cycles, then high → `rx_active` pulses about 8 cycles, no `rx_done`, outputs unchanged from the previous frame.
- Back-to-back 8N1 frames 0x3C then 0xC3, with the next start immediately after the stop bit → two `rx_done` pulses 160 cycles apart with the correct data. Break (line low for 3 frames) → one frame with `stop_error`=1 and `data_parll`=8'h00, no further `rx_done` until the line returns high and falls again.
- Assert `rst`=0 in the middle of the DATA state → all outputs 0 immediately. A new frame after release is received correctly.
